am_lock_removal: RTL
====================

# am_lock_removal

Receive-side counterpart of the TX alignment-marker insertion path, one instance per PCS lane. It consumes 66-bit coded blocks from the lane's block-lock stage and searches for any of the N_LANES alignment markers. It locks to the marker period, reports which logical lane the physical lane carries, checks BIP3 parity, and strips marker blocks from the data stream before lane deskew/reorder.

## Interface
- LEN_CODED_BLOCK, 66, coded block width (2-bit sync header + 64 payload)
- N_LANES, 20, number of distinct markers (IEEE 802.3 Table 82-2, same tables as TX insertion)
- NB_LANE_ID, 5, width of lane id, $clog2(N_LANES)
- AM_PERIOD, 16384, blocks between markers, marker included; sims use 8
- NB_BIP, 8, BIP field width
- N_INVALID_UNLOCK, 4, consecutive bad markers that drop lock
- NB_ERR_CNT, 16, BIP error counter width

- i_clock  in  1  block clock
- i_reset  in  1  asynchronous, active-low reset
- i_valid  in  1  i_data carries a block this cycle
- i_enable  in  1  block enable; a block is processed only when i_valid && i_enable
- i_data  in  LEN_CODED_BLOCK  [65:64] sync header, [63:0] payload
- o_data  out  LEN_CODED_BLOCK  registered copy of processed block
- o_valid  out  1  o_data is a non-marker block (qualified data)
- o_am_found  out  1  pulse: o_data is an accepted marker (removed)
- o_am_lock  out  1  lane is marker-locked
- o_lane_id  out  NB_LANE_ID  logical lane index of locked marker
- o_bip_error  out  1  pulse: BIP3 mismatch on a marker checked while LOCKED
- o_bip_err_cnt  out  NB_ERR_CNT  saturating BIP error count

## Operation
- Marker match for index k: i_data[65:64]==2'b10, {[63:56],[55:48],[47:40]}==LOW[k], {[31:24],[23:16],[15:8]}==HIGH[k], [7:0]==~[39:32]. Any-match = OR over k; match_id = lowest matching k.
- Only processed blocks (i_valid && i_enable) advance counters, BIP or FSM. Otherwise all state holds, o_valid=0, o_am_found=0.
- Block counter cnt: loaded with 0 on an accepted marker, increments per processed block. The "expected marker slot" is the block where cnt==AM_PERIOD-1.
- FSM (registered):
  - FIND_1ST: on any-match, latch lane_id=match_id, clear cnt, go COUNT_1.
  - COUNT_1: at expected slot, block matches lane_id → LOCKED with inv_cnt=0. Anything else → FIND_1ST; this block is not itself re-tested as a first marker.
  - LOCKED: at expected slot, block matches lane_id → inv_cnt=0, BIP check. No match → inv_cnt+1, cnt cleared anyway (slot position retained). When inv_cnt reaches N_INVALID_UNLOCK → FIND_1ST, lane_id held.
- Accepted marker = the FIND_1ST hit, or a matching block at an expected slot. Non-slot blocks that look like markers while in COUNT_1/LOCKED are passed as data.
- BIP accumulator bip_acc: per processed block, bip_acc ^= bipmap(block), with the Table 82-3 bit mapping, same function as TX. On an accepted marker: compare bip_acc with block[39:32] (check only in LOCKED), then bip_acc = bipmap(marker block). The accumulator therefore covers from the previous marker, inclusive, to the current marker, exclusive.
- BIP mismatch: o_bip_error pulses. o_bip_err_cnt increments and saturates at all-ones.
- Marker at an expected slot that fails to match: no BIP check; it is passed as data (o_valid=1).

## Timing
- Latency 1 cycle: o_data, o_valid and o_am_found reflect the block presented in the previous cycle.
- o_am_lock and o_lane_id update in the same cycle the accepting block appears on o_data.
- o_bip_error aligns with o_am_found of the checked marker. The counter updates in the same cycle.
- o_am_lock falls the cycle after the N_INVALID_UNLOCK-th bad slot block.
- Reset (asynchronous, any time, including mid-lock): state=FIND_1ST, cnt=0, inv_cnt=0, bip_acc=0, o_data=0, o_valid=0, o_am_found=0, o_am_lock=0, o_lane_id=0, o_bip_error=0, o_bip_err_cnt=0.

## Test plan
- Lane-7 markers every 8 blocks (AM_PERIOD=8), correct BIP → o_am_lock=1 on 2nd marker's output cycle, o_lane_id=7, o_valid=0 only on marker cycles, o_bip_err_cnt=0.
- Locked, flip one payload bit between markers → single o_bip_error pulse on next marker, o_bip_err_cnt=1, lock retained.
- Locked, corrupt 3 consecutive slot markers then a good one → lock held, inv_cnt cleared. Corrupt 4 → o_am_lock=0 the following cycle.
- FIND hits lane 3, next slot carries lane 4 marker → return to FIND_1ST, o_am_lock stays 0.
- Random i_valid/i_enable gaps on lane-12 stream → lock identical to gapless run, counts unaffected by idle cycles.
- Assert i_reset low while locked with o_bip_err_cnt=5 → all outputs 0 immediately. Relock after two markers.

Source files
------------

// File: rtl/am_lock_removal_if.sv
// Block stream into and out of one PCS lane's alignment-marker lock/removal stage.
interface am_lock_removal_if #(
  parameter int LEN_CODED_BLOCK = 66,
  parameter int NB_LANE_ID      = 5,
  parameter int NB_ERR_CNT      = 16
);
  logic                       i_valid;
  logic                       i_enable;
  logic [LEN_CODED_BLOCK-1:0] i_data;
  logic [LEN_CODED_BLOCK-1:0] o_data;
  logic                       o_valid;
  logic                       o_am_found;
  logic                       o_am_lock;
  logic [NB_LANE_ID-1:0]      o_lane_id;
  logic                       o_bip_error;
  logic [NB_ERR_CNT-1:0]      o_bip_err_cnt;

  modport master (
    output i_valid, i_enable, i_data,
    input  o_data, o_valid, o_am_found, o_am_lock, o_lane_id, o_bip_error, o_bip_err_cnt
  );

  modport slave (
    input  i_valid, i_enable, i_data,
    output o_data, o_valid, o_am_found, o_am_lock, o_lane_id, o_bip_error, o_bip_err_cnt
  );
endinterface

// File: rtl/am_lock_removal.sv
// Per-lane alignment marker lock, lane identification, BIP3 check and marker removal.
// Processed blocks are echoed one cycle later; accepted markers are flagged instead of qualified.
module am_lock_removal #(
  parameter int LEN_CODED_BLOCK  = 66,
  parameter int N_LANES          = 20,
  parameter int NB_LANE_ID       = 5,
  parameter int AM_PERIOD        = 16384,
  parameter int NB_BIP           = 8,
  parameter int N_INVALID_UNLOCK = 4,
  parameter int NB_ERR_CNT       = 16
) (
  input logic               i_clock,
  input logic               i_reset,
  am_lock_removal_if.slave  bus
);

  localparam int NB_CNT = (AM_PERIOD > 1) ? $clog2(AM_PERIOD) : 1;
  localparam int NB_INV = $clog2(N_INVALID_UNLOCK + 1);

  typedef enum logic [1:0] {
    FIND_1ST = 2'd0,
    COUNT_1  = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  // First three marker bytes {M0,M1,M2} per logical lane; M4..M6 are their complement.
  function automatic logic [23:0] am_low(input int k);
    logic [23:0] v;
    case (k)
      0:  v = 24'hC16821;  1:  v = 24'h9D718E;  2:  v = 24'h594BE8;  3:  v = 24'h4D957B;
      4:  v = 24'hF50709;  5:  v = 24'hDD14C2;  6:  v = 24'h9A4A26;  7:  v = 24'h7B4566;
      8:  v = 24'hA02476;  9:  v = 24'h68C9FB;  10: v = 24'hFD6C99;  11: v = 24'hB99155;
      12: v = 24'h5CB9B2;  13: v = 24'h1AF8BD;  14: v = 24'h83C7CA;  15: v = 24'h3536CD;
      16: v = 24'hC4314C;  17: v = 24'hADD6B7;  18: v = 24'h5F662A;  19: v = 24'hC0F0E5;
      default: v = 24'h000000;
    endcase
    return v;
  endfunction

  function automatic logic is_am(input logic [LEN_CODED_BLOCK-1:0] blk, input int k);
    return (blk[65:64] == 2'b10) && (blk[63:40] == am_low(k)) &&
           (blk[31:8] == ~am_low(k)) && (blk[7:0] == ~blk[39:32]);
  endfunction

  // Sync bits 0/1 (i_data[65]/[64]) feed BIP bits 3/4; payload bit 2+8b+i feeds BIP bit i.
  function automatic logic [NB_BIP-1:0] bip_map(input logic [LEN_CODED_BLOCK-1:0] blk);
    logic [7:0]        fold;
    logic [NB_BIP-1:0] bip;
    fold = '0;
    for (int b = 0; b < 8; b++) fold ^= blk[63-8*b -: 8];
    for (int i = 0; i < 8; i++) bip[i] = fold[7-i];
    bip[3] ^= blk[65];
    bip[4] ^= blk[64];
    return bip;
  endfunction

  state_t                     state_q, state_d;
  logic [NB_CNT-1:0]          cnt_q, cnt_d;
  logic [NB_INV-1:0]          inv_q, inv_d;
  logic [NB_LANE_ID-1:0]      lane_id_q, lane_id_d;
  logic [NB_BIP-1:0]          bip_acc_q, bip_acc_d;
  logic [LEN_CODED_BLOCK-1:0] data_q, data_d;
  logic                       valid_q, valid_d;
  logic                       found_q, found_d;
  logic                       bip_err_q, bip_err_d;
  logic [NB_ERR_CNT-1:0]      err_cnt_q, err_cnt_d;

  logic                  proc;
  logic                  any_hit;
  logic [NB_LANE_ID-1:0] match_id;
  logic                  slot_match;
  logic                  at_slot;
  logic                  accept;
  logic                  check_bip;
  logic [NB_BIP-1:0]     blk_bip;

  assign proc    = bus.i_valid && bus.i_enable;
  assign at_slot = (cnt_q == NB_CNT'(AM_PERIOD - 1));
  assign blk_bip = bip_map(bus.i_data);

  // Markers are distinct, so the lowest hit equals the locked lane iff that lane's marker is present.
  always_comb begin
    any_hit  = 1'b0;
    match_id = '0;
    for (int k = N_LANES - 1; k >= 0; k--) begin
      if (is_am(bus.i_data, k)) begin
        any_hit  = 1'b1;
        match_id = NB_LANE_ID'(k);
      end
    end
  end

  assign slot_match = any_hit && (match_id == lane_id_q);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    inv_d     = inv_q;
    lane_id_d = lane_id_q;
    bip_acc_d = bip_acc_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    found_d   = 1'b0;
    bip_err_d = 1'b0;
    err_cnt_d = err_cnt_q;
    accept    = 1'b0;
    check_bip = 1'b0;

    if (proc) begin
      data_d = bus.i_data;
      cnt_d  = cnt_q + 1'b1;
      unique case (state_q)
        FIND_1ST: begin
          if (any_hit) begin
            accept    = 1'b1;
            lane_id_d = match_id;
            state_d   = COUNT_1;
          end
        end
        COUNT_1: begin
          if (at_slot) begin
            if (slot_match) begin
              accept  = 1'b1;
              inv_d   = '0;
              state_d = LOCKED;
            end else begin
              state_d = FIND_1ST;
            end
          end
        end
        LOCKED: begin
          if (at_slot) begin
            if (slot_match) begin
              accept    = 1'b1;
              check_bip = 1'b1;
              inv_d     = '0;
            end else begin
              // A missed marker keeps the slot grid: restart the period from this block.
              cnt_d = '0;
              inv_d = inv_q + 1'b1;
              if (inv_q == NB_INV'(N_INVALID_UNLOCK - 1)) begin
                inv_d   = '0;
                state_d = FIND_1ST;
              end
            end
          end
        end
        default: state_d = FIND_1ST;
      endcase

      if (accept) begin
        cnt_d     = '0;
        bip_acc_d = blk_bip;
      end else begin
        bip_acc_d = bip_acc_q ^ blk_bip;
      end

      if (check_bip && (bip_acc_q != bus.i_data[39:32])) begin
        bip_err_d = 1'b1;
        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
      end

      valid_d = !accept;
      found_d = accept;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= FIND_1ST;
      cnt_q     <= '0;
      inv_q     <= '0;
      lane_id_q <= '0;
      bip_acc_q <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      found_q   <= 1'b0;
      bip_err_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      inv_q     <= inv_d;
      lane_id_q <= lane_id_d;
      bip_acc_q <= bip_acc_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      found_q   <= found_d;
      bip_err_q <= bip_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.o_data        = data_q;
  assign bus.o_valid       = valid_q;
  assign bus.o_am_found    = found_q;
  assign bus.o_am_lock     = (state_q == LOCKED);
  assign bus.o_lane_id     = lane_id_q;
  assign bus.o_bip_error   = bip_err_q;
  assign bus.o_bip_err_cnt = err_cnt_q;

endmodule
